// File: rtl/ibex_rvfi_trace_buf.sv
// On-chip trace buffer for RVFI retire records.
// Supports FIFO, overwrite-ring and trigger-with-post-window capture.
// Readout is through a first-word-fall-through valid/ready port.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | not capturing; buffer contents kept for readout
//   CAPTURE | capturing retires, waiting for trigger in trigger mode
//   POST    | trigger seen; capturing the post-trigger window
//   DONE    | window complete; capture frozen until the next arm
module ibex_rvfi_trace_buf #(
    parameter int unsigned Depth     = 64,
    parameter int unsigned TsWidth   = 24,
    parameter int unsigned PostTrig  = 32,
    parameter int unsigned DropWidth = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       rvfi_valid_i,
    input  logic                       rvfi_trap_i,
    input  logic [31:0]                rvfi_pc_rdata_i,
    input  logic [31:0]                rvfi_insn_i,
    input  logic [4:0]                 rvfi_rd_addr_i,
    input  logic [31:0]                rvfi_rd_wdata_i,
    input  logic [1:0]                 cfg_mode_i,
    input  logic [31:0]                cfg_trig_pc_i,
    input  logic                       cfg_trig_on_trap_i,
    input  logic                       arm_i,
    input  logic                       stop_i,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic [31:0]                rd_pc_o,
    output logic [31:0]                rd_insn_o,
    output logic [4:0]                 rd_rd_addr_o,
    output logic [31:0]                rd_rd_wdata_o,
    output logic                       rd_trap_o,
    output logic [TsWidth-1:0]         rd_ts_o,
    output logic [$clog2(Depth):0]     level_o,
    output logic [DropWidth-1:0]       dropped_o,
    output logic                       capturing_o,
    output logic                       triggered_o,
    output logic                       done_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = AW + 1;
    localparam logic [1:0]  MODE_RING = 2'd1;
    localparam logic [1:0]  MODE_TRIG = 2'd2;
    localparam bit          POST_ZERO = (PostTrig == 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_POST,
        ST_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             mode_q;
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q;
    logic [DropWidth-1:0]   dropped_q;
    logic [TsWidth-1:0]     ts_q;
    logic [AW-1:0]          post_cnt_q;
    logic                   triggered_q;

    logic [31:0]            mem_pc    [Depth];
    logic [31:0]            mem_insn  [Depth];
    logic [4:0]             mem_rd    [Depth];
    logic [31:0]            mem_wdata [Depth];
    logic                   mem_trap  [Depth];
    logic [TsWidth-1:0]     mem_ts    [Depth];

    logic ring_like, trig_mode, active, full, drain_en, have, rd_valid;
    logic pop, cap, overwrite, push, grow, drop_inc, trig_hit, post_last;

    // Datapath qualifiers; mode 3 falls out as FIFO because it is neither ring-like nor trigger.
    always_comb begin
        ring_like = (mode_q == MODE_RING) || (mode_q == MODE_TRIG);
        trig_mode = (mode_q == MODE_TRIG);
        active    = (state_q == ST_CAPTURE) || (state_q == ST_POST);
        full      = (count_q == CW'(Depth));
        have      = (count_q != '0);
        drain_en  = !ring_like || (state_q == ST_IDLE) || (state_q == ST_DONE);
        rd_valid  = have && drain_en;
        pop       = rd_valid && rd_ready_i && !arm_i;
        cap       = rvfi_valid_i && active && !arm_i && !stop_i;
        // Overwrite and pop never coincide: ring-like modes do not drain while active.
        overwrite = cap && full && ring_like;
        push      = cap && (!full || ring_like || pop);
        grow      = push && !overwrite;
        drop_inc  = cap && full && (ring_like || !pop);
        trig_hit  = cap && trig_mode && (state_q == ST_CAPTURE) &&
                    ((rvfi_pc_rdata_i == cfg_trig_pc_i) || (rvfi_trap_i && cfg_trig_on_trap_i));
        post_last = cap && (state_q == ST_POST) && (post_cnt_q == AW'(1));
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode; arm wins over everything, stop over trigger.
    always_comb begin
        state_d = state_q;
        if (arm_i) begin
            state_d = ST_CAPTURE;
        end else begin
            case (state_q)
                ST_CAPTURE: begin
                    if (stop_i)        state_d = ST_IDLE;
                    else if (trig_hit) state_d = POST_ZERO ? ST_DONE : ST_POST;
                end
                ST_POST: begin
                    if (stop_i)         state_d = ST_IDLE;
                    else if (post_last) state_d = ST_DONE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Pointers, occupancy, drop counter, timestamp and post-window down-counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dropped_q   <= '0;
            ts_q        <= '0;
            post_cnt_q  <= '0;
            triggered_q <= 1'b0;
        end else if (arm_i) begin
            mode_q      <= cfg_mode_i;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dropped_q   <= '0;
            ts_q        <= '0;
            post_cnt_q  <= '0;
            triggered_q <= 1'b0;
        end else begin
            ts_q <= ts_q + TsWidth'(1);
            if (push)             wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop || overwrite) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (grow && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !grow) count_q <= count_q - CW'(1);
            if (drop_inc && (dropped_q != '1)) dropped_q <= dropped_q + DropWidth'(1);
            if (trig_hit) begin
                triggered_q <= 1'b1;
                post_cnt_q  <= AW'(PostTrig);
            end else if (cap && (state_q == ST_POST)) begin
                post_cnt_q  <= post_cnt_q - AW'(1);
            end
        end
    end

    // Record storage; contents need no reset since the head is masked while empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_pc[wr_ptr_q]    <= rvfi_pc_rdata_i;
            mem_insn[wr_ptr_q]  <= rvfi_insn_i;
            mem_rd[wr_ptr_q]    <= rvfi_rd_addr_i;
            mem_wdata[wr_ptr_q] <= rvfi_rd_wdata_i;
            mem_trap[wr_ptr_q]  <= rvfi_trap_i;
            mem_ts[wr_ptr_q]    <= ts_q;
        end
    end

    // Head record and status outputs.
    always_comb begin
        rd_valid_o    = rd_valid;
        rd_pc_o       = have ? mem_pc[rd_ptr_q]    : '0;
        rd_insn_o     = have ? mem_insn[rd_ptr_q]  : '0;
        rd_rd_addr_o  = have ? mem_rd[rd_ptr_q]    : '0;
        rd_rd_wdata_o = have ? mem_wdata[rd_ptr_q] : '0;
        rd_trap_o     = have ? mem_trap[rd_ptr_q]  : 1'b0;
        rd_ts_o       = have ? mem_ts[rd_ptr_q]    : '0;
        level_o       = count_q;
        dropped_o     = dropped_q;
        capturing_o   = active;
        triggered_o   = triggered_q;
        done_o        = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_ibex_rvfi_trace_buf.sv
// Directed bench: instance A (Depth 4, TsWidth 4, PostTrig 0, DropWidth 2)
// and instance B (Depth 8, TsWidth 24, PostTrig 2, DropWidth 16) share stimulus.
module tb_ibex_rvfi_trace_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        rvfi_valid, rvfi_trap;
    logic [31:0] rvfi_pc, rvfi_insn, rvfi_wdata;
    logic [4:0]  rvfi_rd;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_trig_pc;
    logic        cfg_on_trap, arm, stop, rd_ready;

    logic        a_rd_valid, a_rd_trap, a_capturing, a_triggered, a_done;
    logic [31:0] a_rd_pc, a_rd_insn, a_rd_wdata;
    logic [4:0]  a_rd_rd;
    logic [3:0]  a_rd_ts;
    logic [2:0]  a_level;
    logic [1:0]  a_dropped;

    logic        b_rd_valid, b_rd_trap, b_capturing, b_triggered, b_done;
    logic [31:0] b_rd_pc, b_rd_insn, b_rd_wdata;
    logic [4:0]  b_rd_rd;
    logic [23:0] b_rd_ts;
    logic [3:0]  b_level;
    logic [15:0] b_dropped;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ibex_rvfi_trace_buf #(.Depth(4), .TsWidth(4), .PostTrig(0), .DropWidth(2)) u_a (
        .clk_i(clk), .rst_i(rst), .rvfi_valid_i(rvfi_valid), .rvfi_trap_i(rvfi_trap),
        .rvfi_pc_rdata_i(rvfi_pc), .rvfi_insn_i(rvfi_insn), .rvfi_rd_addr_i(rvfi_rd),
        .rvfi_rd_wdata_i(rvfi_wdata), .cfg_mode_i(cfg_mode), .cfg_trig_pc_i(cfg_trig_pc),
        .cfg_trig_on_trap_i(cfg_on_trap), .arm_i(arm), .stop_i(stop),
        .rd_valid_o(a_rd_valid), .rd_ready_i(rd_ready), .rd_pc_o(a_rd_pc),
        .rd_insn_o(a_rd_insn), .rd_rd_addr_o(a_rd_rd), .rd_rd_wdata_o(a_rd_wdata),
        .rd_trap_o(a_rd_trap), .rd_ts_o(a_rd_ts), .level_o(a_level), .dropped_o(a_dropped),
        .capturing_o(a_capturing), .triggered_o(a_triggered), .done_o(a_done)
    );

    ibex_rvfi_trace_buf #(.Depth(8), .TsWidth(24), .PostTrig(2), .DropWidth(16)) u_b (
        .clk_i(clk), .rst_i(rst), .rvfi_valid_i(rvfi_valid), .rvfi_trap_i(rvfi_trap),
        .rvfi_pc_rdata_i(rvfi_pc), .rvfi_insn_i(rvfi_insn), .rvfi_rd_addr_i(rvfi_rd),
        .rvfi_rd_wdata_i(rvfi_wdata), .cfg_mode_i(cfg_mode), .cfg_trig_pc_i(cfg_trig_pc),
        .cfg_trig_on_trap_i(cfg_on_trap), .arm_i(arm), .stop_i(stop),
        .rd_valid_o(b_rd_valid), .rd_ready_i(rd_ready), .rd_pc_o(b_rd_pc),
        .rd_insn_o(b_rd_insn), .rd_rd_addr_o(b_rd_rd), .rd_rd_wdata_o(b_rd_wdata),
        .rd_trap_o(b_rd_trap), .rd_ts_o(b_rd_ts), .level_o(b_level), .dropped_o(b_dropped),
        .capturing_o(b_capturing), .triggered_o(b_triggered), .done_o(b_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_retire(input logic [31:0] pc, input logic trap);
        rvfi_valid = 1'b1;
        rvfi_pc    = pc;
        rvfi_insn  = ~pc;
        rvfi_rd    = pc[6:2];
        rvfi_wdata = pc + 32'h1;
        rvfi_trap  = trap;
    endtask

    task automatic quiet();
        rvfi_valid = 1'b0;
        rvfi_trap  = 1'b0;
        arm        = 1'b0;
        stop       = 1'b0;
        rd_ready   = 1'b0;
    endtask

    task automatic do_arm(input logic [1:0] mode);
        cfg_mode = mode;
        arm      = 1'b1;
        tick();
        arm      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        quiet();
        cfg_mode = 2'd0; cfg_trig_pc = 32'h0; cfg_on_trap = 1'b0;
        rvfi_pc = '0; rvfi_insn = '0; rvfi_rd = '0; rvfi_wdata = '0;
        tick(); tick();
        n_vec++; if ({a_rd_valid, a_capturing, a_triggered, a_done, a_level, a_dropped} !== 9'd0) begin n_err++; $display("FAIL reset_a_status: got %0h expected 0", {a_rd_valid, a_capturing, a_triggered, a_done, a_level, a_dropped}); end
        n_vec++; if ({a_rd_pc, a_rd_insn, a_rd_wdata, a_rd_rd, a_rd_trap, a_rd_ts} !== '0) begin n_err++; $display("FAIL reset_a_fields: pc %0h ts %0h expected 0", a_rd_pc, a_rd_ts); end
        n_vec++; if ({b_rd_valid, b_capturing, b_triggered, b_done, b_level, b_dropped} !== 24'd0) begin n_err++; $display("FAIL reset_b_status: got %0h expected 0", {b_rd_valid, b_capturing, b_triggered, b_done, b_level, b_dropped}); end
        rst = 1'b0;
        tick();
        n_vec++; if ({a_capturing, a_done, a_level} !== 5'd0) begin n_err++; $display("FAIL reset_release: got %0h expected 0", {a_capturing, a_done, a_level}); end
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] exp_pc;
        do_arm(2'd0);
        n_vec++; if (a_capturing !== 1'b1) begin n_err++; $display("FAIL fifo_capturing: got %0b expected 1", a_capturing); end
        for (int i = 0; i < 6; i++) begin
            drive_retire(32'h100 + 32'(4 * i), 1'b0);
            tick();
        end
        quiet();
        n_vec++; if (a_level !== 3'd4 || a_dropped !== 2'd2) begin n_err++; $display("FAIL fifo_full: level %0d dropped %0d expected 4 2", a_level, a_dropped); end
        n_vec++; if (a_rd_insn !== ~32'h100 || a_rd_wdata !== 32'h101 || a_rd_rd !== 5'd0) begin n_err++; $display("FAIL fifo_fields: insn %0h wdata %0h rd %0d expected %0h 101 0", a_rd_insn, a_rd_wdata, a_rd_rd, ~32'h100); end
        rd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_pc = 32'h100 + 32'(4 * k);
            n_vec++; if (a_rd_valid !== 1'b1 || a_rd_pc !== exp_pc || a_rd_ts !== 4'(k)) begin n_err++; $display("FAIL fifo_drain%0d: valid %0b pc %0h ts %0d expected 1 %0h %0d", k, a_rd_valid, a_rd_pc, a_rd_ts, exp_pc, k); end
            tick();
        end
        n_vec++; if (a_rd_valid !== 1'b0 || a_level !== 3'd0) begin n_err++; $display("FAIL fifo_empty: valid %0b level %0d expected 0 0", a_rd_valid, a_level); end
        quiet();
    endtask

    task automatic test_ring();
        logic [31:0] exp_pc;
        do_arm(2'd1);
        cfg_mode = 2'd0;
        for (int i = 0; i < 6; i++) begin
            drive_retire(32'h100 + 32'(4 * i), 1'b0);
            tick();
            n_vec++; if (a_rd_valid !== 1'b0) begin n_err++; $display("FAIL ring_no_drain%0d: got %0b expected 0", i, a_rd_valid); end
        end
        drive_retire(32'h118, 1'b0);
        stop = 1'b1;
        tick();
        quiet();
        n_vec++; if (a_capturing !== 1'b0 || a_level !== 3'd4 || a_dropped !== 2'd2) begin n_err++; $display("FAIL ring_stop: capturing %0b level %0d dropped %0d expected 0 4 2", a_capturing, a_level, a_dropped); end
        n_vec++; if (b_level !== 4'd6 || b_dropped !== 16'd0) begin n_err++; $display("FAIL ring_b_level: level %0d dropped %0d expected 6 0", b_level, b_dropped); end
        rd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_pc = 32'h108 + 32'(4 * k);
            n_vec++; if (a_rd_valid !== 1'b1 || a_rd_pc !== exp_pc) begin n_err++; $display("FAIL ring_drain%0d: valid %0b pc %0h expected 1 %0h", k, a_rd_valid, a_rd_pc, exp_pc); end
            tick();
        end
        quiet();
    endtask

    task automatic test_trigger();
        logic [31:0] exp_pc;
        cfg_trig_pc = 32'h40;
        cfg_on_trap = 1'b0;
        do_arm(2'd2);
        for (int i = 0; i < 9; i++) begin
            drive_retire(32'h30 + 32'(4 * i), 1'b0);
            tick();
            if (i == 3) begin
                n_vec++; if (b_triggered !== 1'b0 || b_capturing !== 1'b1) begin n_err++; $display("FAIL trig_pre: triggered %0b capturing %0b expected 0 1", b_triggered, b_capturing); end
            end
            if (i == 4) begin
                n_vec++; if (b_triggered !== 1'b1 || b_done !== 1'b0) begin n_err++; $display("FAIL trig_fire: triggered %0b done %0b expected 1 0", b_triggered, b_done); end
                n_vec++; if (a_done !== 1'b1 || a_triggered !== 1'b1) begin n_err++; $display("FAIL trig_a_done: done %0b triggered %0b expected 1 1", a_done, a_triggered); end
            end
            if (i == 5) begin
                n_vec++; if (b_done !== 1'b0) begin n_err++; $display("FAIL trig_post: done %0b expected 0", b_done); end
            end
            if (i == 6) begin
                n_vec++; if (b_done !== 1'b1 || b_capturing !== 1'b0) begin n_err++; $display("FAIL trig_done: done %0b capturing %0b expected 1 0", b_done, b_capturing); end
            end
        end
        quiet();
        n_vec++; if (b_level !== 4'd7 || b_dropped !== 16'd0) begin n_err++; $display("FAIL trig_b_level: level %0d dropped %0d expected 7 0", b_level, b_dropped); end
        n_vec++; if (a_level !== 3'd4 || a_dropped !== 2'd1 || a_rd_pc !== 32'h34) begin n_err++; $display("FAIL trig_a_buf: level %0d dropped %0d head %0h expected 4 1 34", a_level, a_dropped, a_rd_pc); end
        rd_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            exp_pc = 32'h30 + 32'(4 * k);
            n_vec++; if (b_rd_valid !== 1'b1 || b_rd_pc !== exp_pc) begin n_err++; $display("FAIL trig_drain%0d: valid %0b pc %0h expected 1 %0h", k, b_rd_valid, b_rd_pc, exp_pc); end
            tick();
        end
        n_vec++; if (b_rd_valid !== 1'b0) begin n_err++; $display("FAIL trig_drained: valid %0b expected 0", b_rd_valid); end
        quiet();
    endtask

    task automatic test_trap_trigger();
        cfg_trig_pc = 32'hFFFF_FFF0;
        cfg_on_trap = 1'b1;
        do_arm(2'd2);
        drive_retire(32'h200, 1'b0); tick();
        drive_retire(32'h204, 1'b0); tick();
        n_vec++; if (a_done !== 1'b0) begin n_err++; $display("FAIL trap_early: done %0b expected 0", a_done); end
        drive_retire(32'h208, 1'b1); tick();
        quiet();
        n_vec++; if (a_done !== 1'b1 || a_level !== 3'd3 || a_rd_valid !== 1'b1) begin n_err++; $display("FAIL trap_done: done %0b level %0d valid %0b expected 1 3 1", a_done, a_level, a_rd_valid); end
        rd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (a_rd_pc !== 32'h200 + 32'(4 * k) || a_rd_trap !== (k == 2)) begin n_err++; $display("FAIL trap_drain%0d: pc %0h trap %0b expected %0h %0b", k, a_rd_pc, a_rd_trap, 32'h200 + 32'(4 * k), (k == 2)); end
            tick();
        end
        quiet();
        cfg_on_trap = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        logic [3:0]  exp_ts;
        do_arm(2'd0);
        for (int i = 0; i < 13; i++) tick();
        for (int i = 0; i < 4; i++) begin
            drive_retire(32'h300 + 32'(4 * i), 1'b0);
            tick();
        end
        n_vec++; if (a_level !== 3'd4 || a_dropped !== 2'd0 || a_rd_ts !== 4'd13) begin n_err++; $display("FAIL b2b_full: level %0d dropped %0d ts %0d expected 4 0 13", a_level, a_dropped, a_rd_ts); end
        drive_retire(32'h310, 1'b0);
        rd_ready = 1'b1;
        tick();
        rvfi_valid = 1'b0;
        n_vec++; if (a_level !== 3'd4 || a_dropped !== 2'd0 || a_rd_pc !== 32'h304) begin n_err++; $display("FAIL b2b_pushpop: level %0d dropped %0d head %0h expected 4 0 304", a_level, a_dropped, a_rd_pc); end
        for (int k = 0; k < 4; k++) begin
            exp_pc = 32'h304 + 32'(4 * k);
            exp_ts = 4'd14 + 4'(k);
            n_vec++; if (a_rd_pc !== exp_pc || a_rd_ts !== exp_ts) begin n_err++; $display("FAIL b2b_drain%0d: pc %0h ts %0d expected %0h %0d", k, a_rd_pc, a_rd_ts, exp_pc, exp_ts); end
            tick();
        end
        quiet();
    endtask

    task automatic test_arm_mid_post();
        cfg_trig_pc = 32'h40;
        do_arm(2'd2);
        drive_retire(32'h10, 1'b0); tick();
        drive_retire(32'h14, 1'b0); tick();
        drive_retire(32'h18, 1'b0); tick();
        drive_retire(32'h1c, 1'b0); tick();
        drive_retire(32'h40, 1'b0); tick();
        drive_retire(32'h44, 1'b0); tick();
        n_vec++; if (b_level !== 4'd6 || b_triggered !== 1'b1 || b_capturing !== 1'b1 || b_done !== 1'b0) begin n_err++; $display("FAIL rearm_pre_b: level %0d trig %0b cap %0b done %0b expected 6 1 1 0", b_level, b_triggered, b_capturing, b_done); end
        n_vec++; if (a_dropped !== 2'd1 || a_done !== 1'b1) begin n_err++; $display("FAIL rearm_pre_a: dropped %0d done %0b expected 1 1", a_dropped, a_done); end
        drive_retire(32'h48, 1'b0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        rvfi_valid = 1'b0;
        n_vec++; if (b_level !== 4'd0 || b_dropped !== 16'd0 || b_triggered !== 1'b0 || b_capturing !== 1'b1 || b_done !== 1'b0) begin n_err++; $display("FAIL rearm_b: level %0d dropped %0d trig %0b cap %0b done %0b expected 0 0 0 1 0", b_level, b_dropped, b_triggered, b_capturing, b_done); end
        n_vec++; if (a_level !== 3'd0 || a_dropped !== 2'd0 || a_triggered !== 1'b0 || a_capturing !== 1'b1 || a_done !== 1'b0) begin n_err++; $display("FAIL rearm_a: level %0d dropped %0d trig %0b cap %0b done %0b expected 0 0 0 1 0", a_level, a_dropped, a_triggered, a_capturing, a_done); end
        drive_retire(32'h50, 1'b0);
        tick();
        quiet();
        n_vec++; if (b_level !== 4'd1 || b_rd_ts !== 24'd0 || b_rd_pc !== 32'h50 || b_rd_valid !== 1'b0) begin n_err++; $display("FAIL rearm_first: level %0d ts %0d pc %0h valid %0b expected 1 0 50 0", b_level, b_rd_ts, b_rd_pc, b_rd_valid); end
    endtask

    task automatic test_saturate();
        do_arm(2'd1);
        for (int i = 0; i < 9; i++) begin
            drive_retire(32'h500 + 32'(4 * i), 1'b0);
            tick();
        end
        quiet();
        n_vec++; if (a_dropped !== 2'd3 || a_level !== 3'd4) begin n_err++; $display("FAIL sat_a: dropped %0d level %0d expected 3 4", a_dropped, a_level); end
        n_vec++; if (b_dropped !== 16'd1 || b_level !== 4'd8) begin n_err++; $display("FAIL sat_b: dropped %0d level %0d expected 1 8", b_dropped, b_level); end
    endtask

    task automatic test_reset_mid();
        do_arm(2'd0);
        drive_retire(32'h600, 1'b0); tick();
        drive_retire(32'h604, 1'b0); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        quiet();
        n_vec++; if ({a_rd_valid, a_capturing, a_triggered, a_done, a_level, a_dropped} !== 9'd0 || a_rd_pc !== 32'h0 || a_rd_ts !== 4'd0) begin n_err++; $display("FAIL rst_mid_a: status %0h pc %0h ts %0d expected 0", {a_rd_valid, a_capturing, a_triggered, a_done, a_level, a_dropped}, a_rd_pc, a_rd_ts); end
        n_vec++; if ({b_rd_valid, b_capturing, b_level} !== 6'd0 || b_rd_pc !== 32'h0) begin n_err++; $display("FAIL rst_mid_b: status %0h pc %0h expected 0", {b_rd_valid, b_capturing, b_level}, b_rd_pc); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fifo_overflow();
        test_ring();
        test_trigger();
        test_trap_trigger();
        test_back_to_back();
        test_arm_mid_post();
        test_saturate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
